ddr_tx: RTL

- HDR-DDR serializer that drives SDA toward the SDA handler; counterpart of the RX deserializer.
- Under DDR-CCC control, launches one bit per SCL edge (both edges) for these fields: preamble bits, data bytes, parity pair, CRC token and CRC-5.
- Feeds transmitted data bytes to the CRC block and reports per-field completion back to the DDR-CCC FSM.

---
 rtl/ddr_tx_if.sv | 50 +++++
 rtl/ddr_tx.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ddr_tx_if.sv
// ddr_tx_if: bundles the DDR-CCC, SCL-generator, register-file, CRC and SDA-handler
// signals of the HDR-DDR serializer.
//   slave  : serializer side (ddr_tx)
//   master : the surrounding logic / testbench driving the serializer
interface ddr_tx_if #(
    parameter int unsigned DATA_W = 8
);
    logic              i_sclgen_scl_pos_edge;
    logic              i_sclgen_scl_neg_edge;
    logic              i_ddrccc_tx_en;
    logic [3:0]        i_ddrccc_tx_mode;
    logic [DATA_W-1:0] i_regf_tx_parallel_data;
    logic [4:0]        i_crc_value;
    logic              i_crc_valid;
    logic              o_sdahnd_tx_sda;
    logic              o_ddrccc_tx_mode_done;
    logic              o_crc_en;
    logic              o_crc_data_valid;
    logic [DATA_W-1:0] o_crc_parallel_data;

    modport slave (
        input  i_sclgen_scl_pos_edge,
        input  i_sclgen_scl_neg_edge,
        input  i_ddrccc_tx_en,
        input  i_ddrccc_tx_mode,
        input  i_regf_tx_parallel_data,
        input  i_crc_value,
        input  i_crc_valid,
        output o_sdahnd_tx_sda,
        output o_ddrccc_tx_mode_done,
        output o_crc_en,
        output o_crc_data_valid,
        output o_crc_parallel_data
    );

    modport master (
        output i_sclgen_scl_pos_edge,
        output i_sclgen_scl_neg_edge,
        output i_ddrccc_tx_en,
        output i_ddrccc_tx_mode,
        output i_regf_tx_parallel_data,
        output i_crc_value,
        output i_crc_valid,
        input  o_sdahnd_tx_sda,
        input  o_ddrccc_tx_mode_done,
        input  o_crc_en,
        input  o_crc_data_valid,
        input  o_crc_parallel_data
    );
endinterface

// File: rtl/ddr_tx.sv
// ddr_tx: HDR-DDR serializer. Launches one SDA bit per SCL edge (rising or falling)
// for preamble, data byte, parity pair, CRC token and CRC-5 fields, feeds sent
// bytes to the CRC block and reports field completion to the DDR-CCC FSM.
// Ports:
//   i_sys_clk  : system clock, all logic on its rising edge
//   i_sys_rst  : synchronous active-high reset
//   bus        : ddr_tx_if.slave (SCL edge pulses, field control, byte in,
//                CRC value in, SDA out, done pulse, CRC feed out)
module ddr_tx #(
    parameter int unsigned DATA_W = 8,
    parameter logic [3:0]  TOKEN  = 4'b1100
) (
    input logic     i_sys_clk,
    input logic     i_sys_rst,
    ddr_tx_if.slave bus
);

    localparam int unsigned CNT_W  = $clog2(DATA_W + 1);
    localparam int unsigned HIST_W = 2 * DATA_W;

    localparam logic [3:0] M_PRE_ZERO = 4'b0000;
    localparam logic [3:0] M_PRE_ONE  = 4'b0001;
    localparam logic [3:0] M_BYTE     = 4'b0011;
    localparam logic [3:0] M_TOKEN    = 4'b0101;
    localparam logic [3:0] M_PARITY   = 4'b0110;
    localparam logic [3:0] M_CRC      = 4'b0111;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        CRC_WAIT = 2'd2
    } state_e;

    state_e              state_q, state_n;
    logic [3:0]          mode_q, mode_n;
    logic [DATA_W-1:0]   data_q, data_n;
    logic [DATA_W-1:0]   sh_q, sh_n;
    logic [CNT_W-1:0]    cnt_q, cnt_n;
    logic [HIST_W-1:0]   hist_q, hist_n;
    logic                sda_q, sda_n;
    logic                done_q, done_n;
    logic                crc_en_q, crc_en_n;
    logic                crc_dv_q, crc_dv_n;
    logic [DATA_W-1:0]   crc_data_q, crc_data_n;

    logic scl_edge;
    logic en;
    logic pa1;
    logic pa0;

    // Coincident pos/neg pulses collapse into a single edge
    assign scl_edge = bus.i_sclgen_scl_pos_edge | bus.i_sclgen_scl_neg_edge;
    assign en       = bus.i_ddrccc_tx_en;

    // Parity over the two-byte history: odd bit positions, and even positions inverted
    assign pa1 = ^(hist_q & {DATA_W{2'b10}});
    assign pa0 = ~^(hist_q & {DATA_W{2'b01}});

    // State and output registers
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            state_q    <= IDLE;
            mode_q     <= 4'd0;
            data_q     <= '0;
            sh_q       <= '0;
            cnt_q      <= '0;
            hist_q     <= '0;
            sda_q      <= 1'b1;
            done_q     <= 1'b0;
            crc_en_q   <= 1'b0;
            crc_dv_q   <= 1'b0;
            crc_data_q <= '0;
        end else begin
            state_q    <= state_n;
            mode_q     <= mode_n;
            data_q     <= data_n;
            sh_q       <= sh_n;
            cnt_q      <= cnt_n;
            hist_q     <= hist_n;
            sda_q      <= sda_n;
            done_q     <= done_n;
            crc_en_q   <= crc_en_n;
            crc_dv_q   <= crc_dv_n;
            crc_data_q <= crc_data_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n    = state_q;
        mode_n     = mode_q;
        data_n     = data_q;
        sh_n       = sh_q;
        cnt_n      = cnt_q;
        hist_n     = hist_q;
        sda_n      = sda_q;
        done_n     = 1'b0;
        crc_en_n   = crc_en_q;
        crc_dv_n   = 1'b0;
        crc_data_n = crc_data_q;

        unique case (state_q)
            IDLE: begin
                if (scl_edge && en) begin
                    mode_n = bus.i_ddrccc_tx_mode;
                    data_n = bus.i_regf_tx_parallel_data;
                    case (bus.i_ddrccc_tx_mode)
                        M_PRE_ZERO: begin
                            sda_n  = 1'b0;
                            done_n = 1'b1;
                        end
                        M_PRE_ONE: begin
                            sda_n  = 1'b1;
                            done_n = 1'b1;
                        end
                        M_BYTE: begin
                            sda_n    = bus.i_regf_tx_parallel_data[DATA_W-1];
                            sh_n     = {bus.i_regf_tx_parallel_data[DATA_W-2:0], 1'b0};
                            cnt_n    = CNT_W'(DATA_W - 1);
                            hist_n   = {hist_q[DATA_W-1:0], bus.i_regf_tx_parallel_data};
                            crc_en_n = 1'b1;
                            state_n  = SHIFT;
                        end
                        M_TOKEN: begin
                            sda_n   = TOKEN[3];
                            sh_n    = {TOKEN[2:0], {(DATA_W-3){1'b0}}};
                            cnt_n   = CNT_W'(3);
                            state_n = SHIFT;
                        end
                        M_PARITY: begin
                            sda_n   = pa1;
                            sh_n    = {pa0, {(DATA_W-1){1'b0}}};
                            cnt_n   = CNT_W'(1);
                            state_n = SHIFT;
                        end
                        M_CRC: begin
                            if (bus.i_crc_valid) begin
                                sda_n   = bus.i_crc_value[4];
                                sh_n    = {bus.i_crc_value[3:0], {(DATA_W-4){1'b0}}};
                                cnt_n   = CNT_W'(4);
                                state_n = SHIFT;
                            end else begin
                                state_n = CRC_WAIT;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            SHIFT: begin
                if (!en) begin
                    // Abort: drop the field silently, SDA keeps its last bit
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (scl_edge) begin
                    sda_n = sh_q[DATA_W-1];
                    sh_n  = {sh_q[DATA_W-2:0], 1'b0};
                    cnt_n = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                        if (mode_q == M_BYTE) begin
                            crc_dv_n   = 1'b1;
                            crc_data_n = data_q;
                        end
                        if (mode_q == M_PARITY) begin
                            hist_n = '0;
                        end
                        if (mode_q == M_CRC) begin
                            crc_en_n = 1'b0;
                        end
                    end
                end
            end

            CRC_WAIT: begin
                if (!en) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (scl_edge && bus.i_crc_valid) begin
                    sda_n   = bus.i_crc_value[4];
                    sh_n    = {bus.i_crc_value[3:0], {(DATA_W-4){1'b0}}};
                    cnt_n   = CNT_W'(4);
                    state_n = SHIFT;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.o_sdahnd_tx_sda       = sda_q;
    assign bus.o_ddrccc_tx_mode_done = done_q;
    assign bus.o_crc_en              = crc_en_q;
    assign bus.o_crc_data_valid      = crc_dv_q;
    assign bus.o_crc_parallel_data   = crc_data_q;

endmodule
